// File: rtl/prio_req_arbiter.sv
// Request arbiter with a registered one-hot grant. Each grant is held until the owner
// releases it, the owner drops its request, or the optional hold limit expires.
module prio_req_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           rel,
  input  logic [1:0]     mode,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_vld,
  output logic           timeout
);

  localparam int HW = $clog2(MAX_HOLD + 2);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           to_q, to_d;

  logic [IDW-1:0] win;
  logic           any_req;
  logic           req_known;
  int             rr_idx;

  // A request vector carrying X/Z bits is treated as no request at all.
  assign req_known = !$isunknown(req);
  assign any_req   = (|req) && req_known;

  // Winner selection. Each loop lets the last match override earlier ones.
  always_comb begin
    win    = '0;
    rr_idx = 0;
    case (mode)
      2'b00: begin
        for (int i = 0; i < N; i++) begin
          if (req[i]) win = IDW'(i);
        end
      end
      2'b01: begin
        for (int i = N - 1; i >= 0; i--) begin
          if (req[i]) win = IDW'(i);
        end
      end
      default: begin
        // Walk the offsets from the farthest down to ptr+1, so the nearest offset wins.
        for (int k = N; k >= 1; k--) begin
          rr_idx = (int'(ptr_q) + k) % N;
          if (req[rr_idx]) win = IDW'(rr_idx);
        end
      end
    endcase
  end

  logic owner_drop;
  logic hold_hit;
  assign owner_drop = !req[id_q];
  assign hold_hit   = (MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          gnt_d   = N'(1) << win;
          id_d    = win;
          ptr_d   = win;
          hold_d  = HW'(1);
        end
      end
      GRANT: begin
        if (rel || owner_drop || hold_hit) begin
          state_d = IDLE;
          gnt_d   = '0;
          id_d    = '0;
          to_d    = hold_hit && !rel && !owner_drop;
        end else if ((MAX_HOLD != 0) && !hold_hit) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= IDW'(N - 1);
      hold_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = id_q;
  assign gnt_vld = |gnt_q;
  assign timeout = to_q;

endmodule

// File: tb/tb_prio_req_arbiter.sv
// Bench for prio_req_arbiter: directed vector table, multi-cycle corner sequences and
// random traffic, all compared against a behavioural owner/pointer model.
module tb_prio_req_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int IDW      = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic           rel;
  logic [1:0]     mode;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_vld;
  logic           timeout;

  prio_req_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel), .mode(mode),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: owner index (-1 = nobody), last owner, cycles held, timeout pulse.
  int   m_owner;
  int   m_ptr;
  int   m_hold;
  logic m_to;

  typedef struct {
    logic [N-1:0] req;
    logic         rel;
    logic [1:0]   mode;
    logic [N-1:0] gnt;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick_winner();
    if (mode == 2'b00) begin
      for (int i = N - 1; i >= 0; i--) if (req[i]) return i;
    end else if (mode == 2'b01) begin
      for (int i = 0; i < N; i++) if (req[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = N - 1;
    m_hold  = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_edge();
    int  w;
    bit  owned;
    bit  limit;
    if (m_owner < 0) begin
      m_to = 1'b0;
      if (req != '0) begin
        w       = pick_winner();
        m_owner = w;
        m_ptr   = w;
        m_hold  = 1;
      end
    end else begin
      owned = req[m_owner];
      limit = (MAX_HOLD != 0) && (m_hold == MAX_HOLD);
      if (rel || !owned || limit) begin
        m_to    = limit && !rel && owned;
        m_owner = -1;
      end else begin
        m_to = 1'b0;
        if (m_hold < MAX_HOLD) m_hold++;
      end
    end
  endtask

  task automatic compare_model();
    logic [N-1:0] exp_gnt;
    exp_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("gnt_vld", 32'(gnt_vld), 32'(m_owner >= 0));
    if (m_owner >= 0) chk("gnt_id", 32'(gnt_id), 32'(m_owner));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("onehot0", 32'($onehot0(gnt)), 32'd1);
    chk("to_with_vld", 32'(timeout & gnt_vld), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  initial begin
    int high;

    // Round-robin from reset, then fixed-mode switching, drops and mode 11.
    tbl[0]  = '{4'b1111, 1'b0, 2'b10, 4'b0001};
    tbl[1]  = '{4'b1111, 1'b1, 2'b10, 4'b0000};
    tbl[2]  = '{4'b1111, 1'b0, 2'b10, 4'b0010};
    tbl[3]  = '{4'b1111, 1'b1, 2'b10, 4'b0000};
    tbl[4]  = '{4'b1111, 1'b0, 2'b10, 4'b0100};
    tbl[5]  = '{4'b1111, 1'b1, 2'b10, 4'b0000};
    tbl[6]  = '{4'b1111, 1'b0, 2'b10, 4'b1000};
    tbl[7]  = '{4'b1111, 1'b1, 2'b10, 4'b0000};
    tbl[8]  = '{4'b1111, 1'b0, 2'b10, 4'b0001};
    tbl[9]  = '{4'b1111, 1'b1, 2'b10, 4'b0000};
    tbl[10] = '{4'b0110, 1'b0, 2'b00, 4'b0100};
    tbl[11] = '{4'b0110, 1'b0, 2'b01, 4'b0100};
    tbl[12] = '{4'b0110, 1'b1, 2'b01, 4'b0000};
    tbl[13] = '{4'b0110, 1'b0, 2'b01, 4'b0010};
    tbl[14] = '{4'b0000, 1'b0, 2'b01, 4'b0000};
    tbl[15] = '{4'b0000, 1'b1, 2'b01, 4'b0000};
    tbl[16] = '{4'b1010, 1'b0, 2'b11, 4'b1000};
    tbl[17] = '{4'b0010, 1'b0, 2'b11, 4'b0000};
    tbl[18] = '{4'b0010, 1'b0, 2'b11, 4'b0010};
    tbl[19] = '{4'b0000, 1'b0, 2'b11, 4'b0000};
    tbl[20] = '{4'b0001, 1'b0, 2'b01, 4'b0001};
    tbl[21] = '{4'b0000, 1'b1, 2'b01, 4'b0000};

    rst_n = 1'b0;
    req   = '0;
    rel   = 1'b0;
    mode  = 2'b00;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_gnt_id", 32'(gnt_id), 32'd0);
    chk("reset_gnt_vld", 32'(gnt_vld), 32'd0);
    chk("reset_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      req  = tbl[i].req;
      rel  = tbl[i].rel;
      mode = tbl[i].mode;
      step();
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_timeout", i), 32'(timeout), 32'd0);
    end

    // Hold limit: single requester, no release.
    req  = 4'b0001;
    rel  = 1'b0;
    mode = 2'b01;
    step();
    high = 0;
    for (int c = 0; c < 20 && gnt_vld; c++) begin
      high++;
      step();
    end
    chk("hold_cycles", 32'(high), 32'(MAX_HOLD));
    chk("timeout_pulse", 32'(timeout), 32'd1);
    step();
    chk("regrant_gnt", 32'(gnt), 32'b0001);
    chk("regrant_timeout", 32'(timeout), 32'd0);

    // Release arriving on the same cycle the hold limit is reached.
    repeat (MAX_HOLD - 1) step();
    rel = 1'b1;
    step();
    chk("rel_at_limit_gnt", 32'(gnt), 32'd0);
    chk("rel_at_limit_timeout", 32'(timeout), 32'd0);
    rel = 1'b0;
    req = '0;
    step();
    chk("after_rel_timeout", 32'(timeout), 32'd0);

    // Asynchronous reset in the middle of a grant.
    req  = 4'b1111;
    mode = 2'b10;
    step();
    chk("pre_reset_vld", 32'(gnt_vld), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_gnt", 32'(gnt), 32'd0);
    chk("async_reset_vld", 32'(gnt_vld), 32'd0);
    chk("async_reset_timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_reset_rr_gnt", 32'(gnt), 32'b0001);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) req = N'($urandom_range(0, 15));
      rel  = ($urandom_range(0, 7) == 0);
      mode = 2'($urandom_range(0, 3));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
